// File: rtl/alu_req_scheduler.sv
// Shares one registered-output ALU between two requesters: round-robin grant, one op in flight.
// Latency: accept edge E0 -> EXEC -> CAPT samples unit flag at E2 -> rsp_valid high from E2.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_valid & rsp_ready.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester command handshake; ready is combinational, IDLE only
//   req_a/b/fun       packed per-requester operands and function codes
//   ALU_A/B/FUN       registered operand/function bus to the shared ALU
//   alu_res/flags     {Arith, Logic, CMP, Shift} unit results and done flags, Arith in MSBs
//   alu_carry         carry out of the arithmetic unit
//   rsp_*             response channel: requester id, captured result, carry, error
//
// Optional feature macro: ALU_SCHED_TIMEOUT_EN
//   Defined: CAPT gives up after TIMEOUT flag-low cycles and returns rsp_err=1, rsp_data=0.
//   Undefined: CAPT waits for the unit flag indefinitely and rsp_err is tied low.

module alu_req_scheduler #(
  parameter int unsigned in_width  = 8,
  parameter int unsigned out_width = 16,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*in_width-1:0]  req_a,
  input  logic [2*in_width-1:0]  req_b,
  input  logic [7:0]             req_fun,
  output logic [in_width-1:0]    ALU_A,
  output logic [in_width-1:0]    ALU_B,
  output logic [3:0]             ALU_FUN,
  input  logic [4*out_width-1:0] alu_res,
  input  logic [3:0]             alu_flags,
  input  logic                   alu_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [out_width-1:0]   rsp_data,
  output logic                   rsp_carry,
  output logic                   rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [in_width-1:0]   alu_a_q, alu_a_d;
  logic [in_width-1:0]   alu_b_q, alu_b_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [out_width-1:0]  rsp_data_q, rsp_data_d;
  logic                  rsp_carry_q, rsp_carry_d;

  logic                  any_vld;
  logic                  grant;
  logic [1:0]            ready_mask;
  logic [1:0]            unit_idx;
  logic                  unit_flag;
  logic [out_width-1:0]  unit_res;
  int unsigned           unit_lsb;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_err_q, rsp_err_d;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;  // makes requester 0 win the first contended grant
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_fun_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_fun_q    <= alu_fun_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
`ifdef ALU_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_fun_d    = alu_fun_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    ready_mask   = 2'b00;
`ifdef ALU_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif

    // Round-robin: on contention the requester that did not win last time goes;
    // otherwise the single valid requester (req_valid[1] names it directly).
    any_vld = |req_valid;
    grant   = (&req_valid) ? ~last_grant_q : req_valid[1];

    // Unit select lives in the function MSBs; alu_res/alu_flags put Arith at the top,
    // so the bit/slice index runs opposite to the select code.
    unit_idx  = 2'd3 - alu_fun_q[3:2];
    unit_flag = alu_flags[unit_idx];
    unit_lsb  = 32'(unit_idx) * out_width;
    unit_res  = alu_res[unit_lsb +: out_width];

    case (state_q)
      S_IDLE: begin
        if (any_vld) begin
          ready_mask[grant] = 1'b1;
          alu_a_d      = grant ? req_a[2*in_width-1 -: in_width] : req_a[in_width-1:0];
          alu_b_d      = grant ? req_b[2*in_width-1 -: in_width] : req_b[in_width-1:0];
          alu_fun_d    = grant ? req_fun[7:4] : req_fun[3:0];
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = S_EXEC;
        end
      end

      S_EXEC: begin
        // ALU registers its outputs at the end of this cycle.
        state_d = S_CAPT;
`ifdef ALU_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_CAPT: begin
        if (unit_flag) begin
          rsp_data_d  = unit_res;
          rsp_carry_d = (alu_fun_q[3:2] == 2'b00) && alu_carry;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
`ifdef ALU_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef ALU_SCHED_TIMEOUT_EN
        // cnt_q counts flag-low CAPT cycles already spent; this is the TIMEOUT-th one.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Gate with RST so no command is reported accepted while reset is held.
  assign req_ready = ready_mask & {2{RST}};

  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
`ifdef ALU_SCHED_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: table vectors, hand sequences, randomized run vs reference model.
// Latency: n/a (testbench).
// Backpressure: drives rsp_ready both held and randomized.

module tb_alu_req_scheduler;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_fun;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic [63:0] alu_res   = '0;
  logic [3:0]  alu_flags = '0;
  logic        alu_carry = 1'b0;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_carry, rsp_err;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] flag_mask   = 4'hf;
  logic       carry_force = 1'b0;

  alu_req_scheduler dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .alu_res(alu_res), .alu_flags(alu_flags), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // ALU stub: every unit computes from ALU_A/ALU_B and registers its output each cycle;
  // flags follow flag_mask one cycle later.
  logic [8:0] stub_sum;
  assign stub_sum = {1'b0, ALU_A} + {1'b0, ALU_B};
  always @(posedge CLK) begin
    alu_res   <= {{7'b0, stub_sum}, {ALU_A & ALU_B, ALU_A | ALU_B},
                  {15'b0, ALU_A > ALU_B}, {8'b0, ALU_A} << ALU_B[2:0]};
    alu_flags <= flag_mask;
    alu_carry <= stub_sum[8] | carry_force;
  end

  // Reference result {carry, data} for one op, straight from the unit definitions.
  function automatic logic [16:0] model_op(input logic [3:0] f, input logic [7:0] a,
                                           input logic [7:0] b);
    int s;
    case (f[3:2])
      2'b00:   begin s = int'(a) + int'(b); return {s > 255, 16'(s)}; end
      2'b01:   return {1'b0, a & b, a | b};
      2'b10:   return {1'b0, 16'(a > b ? 1 : 0)};
      default: return {1'b0, 16'(int'(a) * (1 << b[2:0]))};
    endcase
  endfunction

  function automatic logic [1:0] oh(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [1:0]  rv;
    logic [7:0]  a0, b0, a1, b1;
    logic [3:0]  f0, f1;
    logic        cf;
    logic        exp_id;
    logic [15:0] exp_data;
    logic        exp_carry;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    @(negedge CLK);
    req_valid = v.rv; req_a = {v.a1, v.a0}; req_b = {v.b1, v.b0}; req_fun = {v.f1, v.f0};
    carry_force = v.cf; flag_mask = 4'hf; rsp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 8) begin @(negedge CLK); #1; n++; end
    chk({nm, "_grant"}, 32'(req_ready), 32'(oh(v.exp_id)));
    @(negedge CLK); req_valid = 2'b00; #1;
    chk({nm, "_alu_a"},   32'(ALU_A),   32'(v.exp_id ? v.a1 : v.a0));
    chk({nm, "_alu_b"},   32'(ALU_B),   32'(v.exp_id ? v.b1 : v.b0));
    chk({nm, "_alu_fun"}, 32'(ALU_FUN), 32'(v.exp_id ? v.f1 : v.f0));
    chk({nm, "_busy_rdy"}, 32'(req_ready), 32'd0);
    n = 1;
    while (!rsp_valid && n < 10) begin @(negedge CLK); #1; n++; end
    chk({nm, "_latency"}, 32'(n), 32'd3);
    chk({nm, "_id"},    32'(rsp_id),    32'(v.exp_id));
    chk({nm, "_data"},  32'(rsp_data),  32'(v.exp_data));
    chk({nm, "_carry"}, 32'(rsp_carry), 32'(v.exp_carry));
    chk({nm, "_err"},   32'(rsp_err),   32'd0);
    @(negedge CLK); #1;
    chk({nm, "_done"}, 32'(rsp_valid), 32'd0);
    carry_force = 1'b0;
  endtask

  // ---------------- randomized model ----------------
  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic        carry;
  } exp_t;

  exp_t q[$];
  logic m_idle = 1'b1;
  logic m_last = 1'b1;
  logic m_hold = 1'b0;
  int   m_age  = 0;

  task automatic step(input bit rnd);
    logic [1:0]  exp_rdy;
    logic        pick;
    logic [16:0] r;
    exp_t        e;
    @(negedge CLK);
    if (rnd) begin
      req_valid = 2'($urandom_range(0, 3));
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      req_fun   = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flag_mask = 4'($urandom_range(0, 15));
    end else begin
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      flag_mask = 4'hf;
    end
    #1;
    pick    = (req_valid == 2'b11) ? ~m_last : req_valid[1];
    exp_rdy = (m_idle && req_valid != 2'b00) ? oh(pick) : 2'b00;
    chk("rr_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_hold) chk("rsp_hold", 32'(rsp_valid), 32'd1);
    if (exp_rdy != 2'b00) begin
      r = model_op(pick ? req_fun[7:4] : req_fun[3:0],
                   pick ? req_a[15:8] : req_a[7:0],
                   pick ? req_b[15:8] : req_b[7:0]);
      e.id = pick; e.data = r[15:0]; e.carry = r[16];
      q.push_back(e);
      m_last = pick; m_idle = 1'b0; m_age = 0;
    end else if (!m_idle) begin
      m_age++;
      if (m_age < 3) chk("early_rsp", 32'(rsp_valid), 32'd0);
    end
    m_hold = 1'b0;
    if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rnd_id",    32'(rsp_id),    32'(q[0].id));
        chk("rnd_data",  32'(rsp_data),  32'(q[0].data));
        chk("rnd_carry", 32'(rsp_carry), 32'(q[0].carry));
        chk("rnd_err",   32'(rsp_err),   32'd0);
        if (rsp_ready) begin
          void'(q.pop_front());
          m_idle = 1'b1;
        end else begin
          m_hold = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int n;
    logic [16:0] r;

    //       rv     a0     b0     a1     b1     f0       f1       cf    id    data       carry
    tbl[0] = '{2'b01, 8'h05, 8'h03, 8'h00, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0008, 1'b0};
    tbl[1] = '{2'b11, 8'h11, 8'h22, 8'h05, 8'h02, 4'b0000, 4'b1101, 1'b1, 1'b1, 16'h0014, 1'b0};
    tbl[2] = '{2'b11, 8'hFF, 8'h01, 8'h33, 8'h44, 4'b0011, 4'b0100, 1'b0, 1'b0, 16'h0100, 1'b1};
    tbl[3] = '{2'b10, 8'h00, 8'h00, 8'hF0, 8'h3C, 4'b0000, 4'b0100, 1'b0, 1'b1, 16'h30FC, 1'b0};
    tbl[4] = '{2'b11, 8'h09, 8'h03, 8'h01, 8'h01, 4'b1000, 4'b0000, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[5] = '{2'b11, 8'h04, 8'h04, 8'h02, 8'h07, 4'b0000, 4'b1010, 1'b0, 1'b1, 16'h0000, 1'b0};

    // Reset state, with both requesters asserting.
    RST = 1'b0; req_valid = 2'b11; req_a = 16'h2211; req_b = 16'h4433; req_fun = 8'h00;
    rsp_ready = 1'b1;
    #12;
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_valid",   32'(rsp_valid), 32'd0);
    chk("rst_alu_a",   32'(ALU_A),     32'd0);
    chk("rst_alu_b",   32'(ALU_B),     32'd0);
    chk("rst_alu_fun", 32'(ALU_FUN),   32'd0);
    chk("rst_id",      32'(rsp_id),    32'd0);
    chk("rst_data",    32'(rsp_data),  32'd0);
    chk("rst_err",     32'(rsp_err),   32'd0);

    // Contention: grants alternate 0,1,0,1, one accept every 4 cycles.
    @(negedge CLK); RST = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("contend_ready", 32'(req_ready), (c % 4 == 0) ? 32'(oh(((c / 4) % 2) == 1)) : 32'd0);
      if (c == 3 || c == 7) begin
        chk("contend_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("contend_rsp_id",    32'(rsp_id),    (c == 3) ? 32'd0 : 32'd1);
      end
      @(negedge CLK);
    end
    req_valid = 2'b00;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: response and ALU bus frozen while rsp_ready is low.
    @(negedge CLK);
    req_valid = 2'b01; req_a = 16'h0077; req_b = 16'h0011; req_fun = 8'h04;
    rsp_ready = 1'b0; flag_mask = 4'hf;
    #1; chk("bp_grant", 32'(req_ready), 32'd1);
    @(negedge CLK); req_valid = 2'b11; #1;
    chk("bp_alu_a", 32'(ALU_A), 32'h77);
    n = 1;
    while (!rsp_valid && n < 10) begin @(negedge CLK); #1; n++; end
    chk("bp_latency", 32'(n), 32'd3);
    r = model_op(4'h4, 8'h77, 8'h11);
    repeat (5) begin
      @(negedge CLK); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data",  32'(rsp_data),  32'(r[15:0]));
      chk("bp_id",    32'(rsp_id),    32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_alu_a", 32'(ALU_A),     32'h77);
    end
    @(negedge CLK); rsp_ready = 1'b1; #1;
    chk("bp_release_valid", 32'(rsp_valid), 32'd1);
    @(negedge CLK); #1;
    chk("bp_next_ready", 32'(req_ready), 32'b10);
    chk("bp_next_valid", 32'(rsp_valid), 32'd0);
    req_valid = 2'b00;

    // Reset while in EXEC.
    @(negedge CLK);
    req_valid = 2'b01; req_a = 16'h005A; req_b = 16'h00A5; req_fun = 8'h0F;
    #1; chk("rx_grant", 32'(req_ready), 32'd1);
    @(negedge CLK); req_valid = 2'b11; #1;
    chk("rx_alu_a_exec", 32'(ALU_A), 32'h5A);
    RST = 1'b0; #1;
    chk("rx_alu_a",   32'(ALU_A),     32'd0);
    chk("rx_alu_b",   32'(ALU_B),     32'd0);
    chk("rx_alu_fun", 32'(ALU_FUN),   32'd0);
    chk("rx_valid",   32'(rsp_valid), 32'd0);
    chk("rx_ready",   32'(req_ready), 32'd0);
    @(negedge CLK); RST = 1'b1; #1;
    chk("rx_first_grant", 32'(req_ready), 32'b01);
    req_valid = 2'b00;

    // Randomized run against the model, then drain.
    m_idle = 1'b1; m_last = 1'b1; m_hold = 1'b0;
    repeat (800) step(1'b1);
    repeat (20)  step(1'b0);
    chk("drain_queue", 32'(q.size()), 32'd0);
    chk("drain_idle",  32'(m_idle),   32'd1);

    // Unit flag never arrives.
    @(negedge CLK);
    req_valid = 2'b01; req_a = 16'h0003; req_b = 16'h0004; req_fun = 8'h00;
    flag_mask = 4'h0; rsp_ready = 1'b1;
    #1; chk("to_grant", 32'(req_ready), 32'd1);
    @(negedge CLK); req_valid = 2'b00; #1;
`ifdef ALU_SCHED_TIMEOUT_EN
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge CLK); #1; n++; end
    chk("to_latency", 32'(n),         32'd17);
    chk("to_err",     32'(rsp_err),   32'd1);
    chk("to_data",    32'(rsp_data),  32'd0);
    chk("to_carry",   32'(rsp_carry), 32'd0);
    @(negedge CLK); #1;
    chk("to_done", 32'(rsp_valid), 32'd0);
`else
    n = 0;
    repeat (120) begin
      @(negedge CLK); #1;
      if (rsp_valid) n++;
    end
    chk("no_timeout", 32'(n), 32'd0);
    chk("no_timeout_err", 32'(rsp_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
